// File: rtl/plot_pkg.sv
// Shared object codes, plotter state encoding and default colours for the
// object plotter and its raster scanner.
package plot_pkg;

    typedef enum logic [1:0] {
        OBJ_BALL   = 2'b00,
        OBJ_PADDLE = 2'b01,
        OBJ_BRICK  = 2'b10,
        OBJ_NONE   = 2'b11
    } objCodeT;

    typedef enum logic [1:0] {
        IDLE,
        ERASE,
        DRAW,
        DONE
    } plotStateT;

    localparam logic [2:0] DEF_BG_COLOUR     = 3'b000;
    localparam logic [2:0] DEF_BALL_COLOUR   = 3'b111;
    localparam logic [2:0] DEF_PADDLE_COLOUR = 3'b011;

endpackage

// File: rtl/rect_scanner.sv
// Restartable row-major x/y counter pair: one coordinate per clock over a
// rectangle, with a registered on-screen flag for the current coordinate.
module rect_scanner #(
    parameter logic [8:0] LIMIT_X = 9'd159,
    parameter logic [7:0] LIMIT_Y = 8'd119
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] originX,
    input  logic [6:0] originY,
    input  logic [7:0] sizeX,
    input  logic [6:0] sizeY,
    output logic [7:0] scanX,
    output logic [6:0] scanY,
    output logic       valid,
    output logic       visible,
    output logic       last
);

    // Wide counters so a rectangle hanging off the right/bottom edge never wraps.
    logic [8:0] curX, baseX, endX, nxtX, nxtBaseX, nxtEndX;
    logic [7:0] curY, endY, nxtY, nxtEndY;
    logic       nxtValid;

    assign last  = valid && (curX == endX) && (curY == endY);
    assign scanX = curX[7:0];
    assign scanY = curY[6:0];

    always_comb begin
        nxtX     = curX;
        nxtY     = curY;
        nxtValid = valid;
        nxtBaseX = baseX;
        nxtEndX  = endX;
        nxtEndY  = endY;
        if (start) begin
            nxtX     = {1'b0, originX};
            nxtY     = {1'b0, originY};
            nxtValid = 1'b1;
            nxtBaseX = {1'b0, originX};
            nxtEndX  = {1'b0, originX} + {1'b0, sizeX} - 9'd1;
            nxtEndY  = {1'b0, originY} + {1'b0, sizeY} - 8'd1;
        end else if (valid) begin
            if (last) begin
                nxtValid = 1'b0;
            end else if (curX == endX) begin
                nxtX = baseX;
                nxtY = curY + 8'd1;
            end else begin
                nxtX = curX + 9'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            curX    <= '0;
            curY    <= '0;
            baseX   <= '0;
            endX    <= '0;
            endY    <= '0;
            valid   <= 1'b0;
            visible <= 1'b0;
        end else begin
            curX    <= nxtX;
            curY    <= nxtY;
            baseX   <= nxtBaseX;
            endX    <= nxtEndX;
            endY    <= nxtEndY;
            valid   <= nxtValid;
            visible <= nxtValid && (nxtX <= LIMIT_X) && (nxtY <= LIMIT_Y);
        end
    end

endmodule

// File: rtl/object_plotter.sv
// Renders game-logic plot requests into the VGA adapter frame buffer: erase the
// old rectangle to background, then draw the new one, one pixel per clock.
module object_plotter
    import plot_pkg::*;
#(
    parameter int         MAX_X         = 159,
    parameter int         MAX_Y         = 119,
    parameter logic [2:0] BG_COLOUR     = DEF_BG_COLOUR,
    parameter logic [2:0] BALL_COLOUR   = DEF_BALL_COLOUR,
    parameter logic [2:0] PADDLE_COLOUR = DEF_PADDLE_COLOUR
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       startPlot,
    input  logic [1:0] object,
    input  logic [7:0] newX,
    input  logic [6:0] newY,
    input  logic [7:0] oldX,
    input  logic [6:0] oldY,
    input  logic [7:0] sizeX,
    input  logic [6:0] sizeY,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       dropped
);

    plotStateT  state, stateNext;
    objCodeT    objReg, reqObj;
    logic [7:0] newXReg, sizeXReg, scanOriginX, scanSizeX;
    logic [6:0] newYReg, sizeYReg, scanOriginY, scanSizeY;
    logic       accept, scanStart, scanValid, scanLast;
    logic [2:0] colourNext;

    rect_scanner #(
        .LIMIT_X(9'(MAX_X)),
        .LIMIT_Y(8'(MAX_Y))
    ) scanner (
        .clk    (clk),
        .resetn (resetn),
        .start  (scanStart),
        .originX(scanOriginX),
        .originY(scanOriginY),
        .sizeX  (scanSizeX),
        .sizeY  (scanSizeY),
        .scanX  (x),
        .scanY  (y),
        .valid  (scanValid),
        .visible(plot),
        .last   (scanLast)
    );

    // In IDLE the scanner is fed straight from the request inputs so the first
    // pixel is on the bus the cycle after the start is accepted.
    always_comb begin
        stateNext   = state;
        accept      = 1'b0;
        scanStart   = 1'b0;
        reqObj      = objReg;
        scanOriginX = newXReg;
        scanOriginY = newYReg;
        scanSizeX   = sizeXReg;
        scanSizeY   = sizeYReg;
        case (state)
            IDLE: begin
                reqObj    = objCodeT'(object);
                scanSizeX = sizeX;
                scanSizeY = sizeY;
                if (startPlot && reqObj != OBJ_NONE) begin
                    accept = 1'b1;
                    if (sizeX == 8'd0 || sizeY == 7'd0) begin
                        stateNext = DONE;
                    end else if (reqObj != OBJ_BRICK && oldX == newX && oldY == newY) begin
                        stateNext   = DRAW;
                        scanStart   = 1'b1;
                        scanOriginX = newX;
                        scanOriginY = newY;
                    end else begin
                        stateNext   = ERASE;
                        scanStart   = 1'b1;
                        scanOriginX = oldX;
                        scanOriginY = oldY;
                    end
                end
            end
            ERASE: begin
                if (scanValid && scanLast) begin
                    if (objReg == OBJ_BRICK) begin
                        stateNext = DONE;
                    end else begin
                        stateNext = DRAW;
                        scanStart = 1'b1;
                    end
                end
            end
            DRAW: begin
                if (scanValid && scanLast) stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        colourNext = 3'b000;
        if (stateNext == ERASE) begin
            colourNext = BG_COLOUR;
        end else if (stateNext == DRAW) begin
            colourNext = (reqObj == OBJ_PADDLE) ? PADDLE_COLOUR : BALL_COLOUR;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            colour  <= 3'b000;
            busy    <= 1'b0;
            done    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            state   <= stateNext;
            colour  <= colourNext;
            busy    <= (stateNext == ERASE) || (stateNext == DRAW);
            done    <= (stateNext == DONE);
            dropped <= startPlot && (state != IDLE);
        end
    end

    // Request data only changes on an accepted start; no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            objReg   <= reqObj;
            newXReg  <= newX;
            newYReg  <= newY;
            sizeXReg <= sizeX;
            sizeYReg <= sizeY;
        end
    end

endmodule

// File: tb/tb_object_plotter.sv
// Directed bench for object_plotter: pixel-by-pixel comparison of erase/draw
// passes, clipping, dropped starts, ignored requests and asynchronous reset.
module tb_object_plotter;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       startPlot = 1'b0;
    logic [1:0] object = 2'b11;
    logic [7:0] newX = '0, oldX = '0, sizeX = '0;
    logic [6:0] newY = '0, oldY = '0, sizeY = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done, dropped;

    int checks = 0;
    int errors = 0;

    logic [31:0] fullWord;
    logic [31:0] ctrlWord;
    assign fullWord = {10'b0, dropped, busy, done, plot, colour, x, y};
    assign ctrlWord = {28'b0, dropped, busy, done, plot};

    object_plotter dut (
        .clk      (clk),
        .resetn   (resetn),
        .startPlot(startPlot),
        .object   (object),
        .newX     (newX),
        .newY     (newY),
        .oldX     (oldX),
        .oldY     (oldY),
        .sizeX    (sizeX),
        .sizeY    (sizeY),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy),
        .done     (done),
        .dropped  (dropped)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pix(input logic drp, input logic bsy, input logic dn,
                                        input logic plt, input logic [2:0] col,
                                        input int px, input int py);
        return {10'b0, drp, bsy, dn, plt, col, px[7:0], py[6:0]};
    endfunction

    // Called at a falling edge; checks every cycle up to and including the idle
    // cycle after done. dropAt>0 pulses a junk start during that cycle.
    task automatic runReq(input string name, input logic [1:0] obj,
                          input int ox, input int oy, input int nx, input int ny,
                          input int sx, input int sy,
                          input bit hasErase, input bit hasDraw, input logic [2:0] drawCol,
                          input int total, input int dropAt);
        logic [31:0] expq[$];
        logic [31:0] exp;
        logic        drp;
        if (hasErase)
            for (int yy = oy; yy < oy + sy; yy++)
                for (int xx = ox; xx < ox + sx; xx++)
                    expq.push_back(pix(1'b0, 1'b1, 1'b0, (xx <= 159 && yy <= 119), 3'b000, xx, yy));
        if (hasDraw)
            for (int yy = ny; yy < ny + sy; yy++)
                for (int xx = nx; xx < nx + sx; xx++)
                    expq.push_back(pix(1'b0, 1'b1, 1'b0, (xx <= 159 && yy <= 119), drawCol, xx, yy));
        object = obj;
        oldX = 8'(ox); oldY = 7'(oy);
        newX = 8'(nx); newY = 7'(ny);
        sizeX = 8'(sx); sizeY = 7'(sy);
        startPlot = 1'b1;
        for (int k = 1; k <= total + 1; k++) begin
            @(negedge clk);
            if (k == 1 || k == dropAt + 1) startPlot = 1'b0;
            drp = (dropAt != 0) && (k == dropAt + 1);
            if (k < total) begin
                exp = (k - 1 < expq.size()) ? expq[k-1] : 32'h0;
                exp[21] = drp;
                checkVal($sformatf("%s px%0d", name, k), fullWord, exp);
            end else if (k == total) begin
                checkVal($sformatf("%s done", name), ctrlWord, {28'b0, drp, 3'b010});
            end else begin
                checkVal($sformatf("%s idle", name), ctrlWord, {28'b0, drp, 3'b000});
            end
            if (k == dropAt) begin
                startPlot = 1'b1;
                object = 2'b10;
                newX = newX + 8'd40;
                newY = 7'd3;
                sizeX = 8'd50;
            end
        end
    endtask

    initial begin
        @(negedge clk);
        checkVal("reset outputs", fullWord, 32'h0);
        resetn = 1'b1;

        runReq("ball_move", 2'b00, 10, 20, 11, 21, 4, 4, 1, 1, 3'b111, 33, 0);
        runReq("paddle_still", 2'b01, 100, 117, 100, 117, 20, 1, 0, 1, 3'b011, 21, 0);
        runReq("brick", 2'b10, 16, 10, 16, 10, 16, 10, 1, 0, 3'b000, 161, 0);
        runReq("clip", 2'b00, 150, 110, 157, 117, 4, 4, 1, 1, 3'b111, 33, 0);
        runReq("drop_mid", 2'b00, 40, 40, 42, 43, 4, 4, 1, 1, 3'b111, 33, 5);
        runReq("drop_done", 2'b01, 50, 117, 54, 117, 8, 1, 1, 1, 3'b011, 17, 17);
        runReq("size_zero", 2'b00, 1, 1, 2, 2, 0, 4, 0, 0, 3'b000, 1, 0);

        // Object code 11 must be ignored entirely.
        object = 2'b11; oldX = 8'd5; oldY = 7'd5; newX = 8'd6; newY = 7'd6;
        sizeX = 8'd4; sizeY = 7'd4;
        startPlot = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            startPlot = 1'b0;
            checkVal($sformatf("obj_none c%0d", k), ctrlWord, 32'h0);
        end

        // Reset in the middle of the draw pass.
        object = 2'b00; oldX = 8'd30; oldY = 7'd30; newX = 8'd31; newY = 7'd31;
        sizeX = 8'd4; sizeY = 7'd4;
        startPlot = 1'b1;
        @(negedge clk);
        startPlot = 1'b0;
        repeat (19) @(negedge clk);
        checkVal("pre_reset draw px", fullWord, pix(1'b0, 1'b1, 1'b0, 1'b1, 3'b111, 34, 31));
        #2 resetn = 1'b0;
        #1 checkVal("async reset", fullWord, 32'h0);
        @(negedge clk);
        checkVal("held reset", fullWord, 32'h0);
        resetn = 1'b1;
        runReq("after_reset", 2'b00, 10, 20, 11, 21, 4, 4, 1, 1, 3'b111, 33, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/object_plotter.md
# object_plotter

Consumes the plot requests issued by the game-logic block (object code, new/old origin, size, `startPlot` strobe) and renders them into the DE2 VGA adapter's frame buffer one pixel per clock. It erases the object's old rectangle to background, then draws the new rectangle in the object's colour. It sits between game logic and the `vga_adapter` write port (`x`, `y`, `colour`, `plot`).

## Interface
Parameters:
- `MAX_X`, default 159: last visible column; pixels beyond it are suppressed.
- `MAX_Y`, default 119: last visible row; pixels beyond it are suppressed.
- `BG_COLOUR`, default 3'b000: erase colour.
- `BALL_COLOUR`, default 3'b111: draw colour for the ball (object 2'b00).
- `PADDLE_COLOUR`, default 3'b011: draw colour for the paddle (object 2'b01).

Ports. One clock; reset is asynchronous and active-low.
- `clk`, in, 1: system clock.
- `resetn`, in, 1: asynchronous active-low reset.
- `startPlot`, in, 1: request strobe, sampled each cycle.
- `object`, in, 2: 00 ball, 01 paddle, 10 brick (erase only), 11 none.
- `newX`, in, 8 / `newY`, in, 7: origin of the new rectangle.
- `oldX`, in, 8 / `oldY`, in, 7: origin of the old rectangle.
- `sizeX`, in, 8 / `sizeY`, in, 7: rectangle width and height in pixels.
- `x`, out, 8 / `y`, out, 7 / `colour`, out, 3 / `plot`, out, 1: pixel write to the VGA adapter.
- `busy`, out, 1: high from the cycle after an accepted start until `done`.
- `done`, out, 1: one-cycle pulse when a request finishes.
- `dropped`, out, 1: one-cycle pulse when a `startPlot` arrives while busy.

## Operation
- States are IDLE, ERASE, DRAW, DONE.
- **IDLE.** On `startPlot`=1 with `object`≠11, latch all request inputs and go to ERASE. Go straight to DRAW if `oldX==newX && oldY==newY` and the object is the ball or paddle.
  - `object`=11 is ignored and produces no `done`.
- **ERASE.** Raster-scan the old rectangle in row-major order, x fastest: x from oldX to oldX+sizeX-1, y from oldY to oldY+sizeY-1. Colour is `BG_COLOUR`.
  - On the last pixel: brick goes to DONE; ball and paddle go to DRAW.
- **DRAW.** Same scan over the new rectangle, using `BALL_COLOUR` or `PADDLE_COLOUR`. Go to DONE after the last pixel.
- **DONE.** Pulse `done`, then go to IDLE.
- **Size zero.** `sizeX`==0 or `sizeY`==0 makes both passes empty: IDLE→DONE directly.
- **Clipping.** Scan arithmetic uses 9-bit x and 8-bit y, with no wrap. Pixels with x>`MAX_X` or y>`MAX_Y` still consume their cycle but hold `plot`=0.
- **Start while busy.** `startPlot` in any state other than IDLE is discarded and pulses `dropped`. Latched request values are never overwritten mid-request.
- **Reset.** Any state goes to IDLE immediately. Every output is 0 on reset, including `x`, `y`, `colour`, `plot`, `busy`, `done` and `dropped`.

## Timing
- All outputs are registered.
- `startPlot` sampled at edge N gives the first `plot` pixel at edge N+1, with `busy`=1 from N+1.
- One pixel per cycle, no stalls. Each pass takes sizeX·sizeY cycles.
- `done` is high for exactly one cycle, the cycle after the last pixel. `busy` falls in that same cycle.
  - A new `startPlot` in the `done` cycle is dropped.
  - A new `startPlot` in the next cycle (IDLE) is accepted.
- Ball request (4×4, moved): 16 erase + 16 draw + 1 done = 33 cycles.
- Brick request (16×10): 160 + 1 = 161 cycles.
- `plot` is 0 in IDLE and DONE.

## Structure
- Package `plot_pkg` holds:
  - the object codes 2'b00, 2'b01, 2'b10 and 2'b11;
  - the state enum for IDLE, ERASE, DRAW and DONE;
  - the default colour constants.
- Sub-module `rect_scanner` is a restartable x/y counter pair.
  - Inputs: `start`, origin, size.
  - Outputs: scan coordinate, `valid`, `last`.
  - It is instantiated once and reused for both passes; the top-level FSM restarts it with the new origin.

## Test plan
1. **Moving ball.** Reset, then ball (obj 00) with old (10,20), new (11,21), size 4×4 -> 16 pixels at (10..13,20..23) colour 000, then 16 at (11..14,21..24) colour 111, then `done` at cycle 33.
2. **Stationary paddle.** Paddle with old==new (100,117), size 20×1 -> no erase, 20 pixels colour 011, `done` at cycle 21.
3. **Brick erase.** Brick (obj 10) at (16,10), size 16×10 -> 160 pixels colour 000, no draw pass, `done` at cycle 161.
4. **Clipping.** Ball new (157,117), size 4×4 -> `plot` low for x=160 and y=120; the request still completes in 33 cycles.
5. **Start while busy.** Pulse `startPlot` at cycle 5 of a request -> `dropped` pulses and the first request completes unchanged. Pulse `startPlot` with obj 11 -> no activity and no `done`.
6. **Reset mid-draw.** Deassert `resetn` mid-draw -> all outputs 0 asynchronously and the state is IDLE. After release, a new request runs normally.
